// File: rtl/my_alu_if.sv
// Operand/result bundle for my_alu: the driver owns operands and enable,
// the ALU owns the combinational and registered results.
interface my_alu_if;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ALUControl;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;
    logic [31:0] ResultQ;
    logic [3:0]  ALUFlagsQ;

    modport master (
        output en, a, b, ALUControl,
        input  Result, ALUFlags, ResultQ, ALUFlagsQ
    );

    modport slave (
        input  en, a, b, ALUControl,
        output Result, ALUFlags, ResultQ, ALUFlagsQ
    );
endinterface

// File: rtl/my_alu.sv
// 32-bit ALU with ARM-style NZCV flags: zero-latency datapath outputs plus
// an enable-gated registered copy for pipeline and flag-register logic.
module my_alu (
    input  logic    clk,
    input  logic    reset_n,
    my_alu_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ORR = 3'b011,
        OP_EOR = 3'b100,
        OP_BIC = 3'b101,
        OP_LSL = 3'b110,
        OP_LSR = 3'b111
    } alu_op_e;

    alu_op_e     op;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic [7:0]  shamt;
    logic [31:0] res;
    logic        c;
    logic        v;

    assign op    = alu_op_e'(bus.ALUControl);
    assign shamt = bus.b[7:0];

    // SUB reuses the adder as a + ~b + 1, so C=1 means "no borrow".
    // NOTE: combinational logic uses blocking '=' with every output defaulted
    // first, so no path through the case can infer a latch.
    always_comb begin
        b_eff = (op == OP_SUB) ? ~bus.b : bus.b;
        sum   = {1'b0, bus.a} + {1'b0, b_eff} + {32'd0, op == OP_SUB};
        res   = '0;
        c     = 1'b0;
        v     = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res = sum[31:0];
                c   = sum[32];
                v   = (bus.a[31] == b_eff[31]) && (sum[31] != bus.a[31]);
            end
            OP_AND:  res = bus.a & bus.b;
            OP_ORR:  res = bus.a | bus.b;
            OP_EOR:  res = bus.a ^ bus.b;
            OP_BIC:  res = bus.a & ~bus.b;
            OP_LSL:  res = (shamt >= 8'd32) ? '0 : bus.a << shamt[4:0];
            OP_LSR:  res = (shamt >= 8'd32) ? '0 : bus.a >> shamt[4:0];
            default: res = '0;
        endcase
    end

    assign bus.Result   = res;
    assign bus.ALUFlags = {res[31], res == 32'd0, c, v};

    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ResultQ   <= '0;
            bus.ALUFlagsQ <= '0;
        end else if (bus.en) begin
            bus.ResultQ   <= res;
            bus.ALUFlagsQ <= bus.ALUFlags;
        end
    end
endmodule

// File: tb/tb_my_alu.sv
// Scoreboard bench for my_alu: stimulus pushes expected values, a negedge
// monitor pops and compares either the combinational or registered outputs.
module tb_my_alu;
    logic clk;
    logic reset_n;

    my_alu_if bus ();

    my_alu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          reg_path;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare one pending expectation per negedge, away from the active edge.
    initial begin
        exp_t item;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                item = sb.pop_front();
                if (item.reg_path) begin
                    check({item.name, " ResultQ"},   bus.ResultQ,           item.res);
                    check({item.name, " ALUFlagsQ"}, {28'd0, bus.ALUFlagsQ}, {28'd0, item.flg});
                end else begin
                    check({item.name, " Result"},    bus.Result,            item.res);
                    check({item.name, " ALUFlags"},  {28'd0, bus.ALUFlags}, {28'd0, item.flg});
                end
            end
        end
    end

    task automatic push(input string name, input bit reg_path,
                        input logic [31:0] res, input logic [3:0] flg);
        exp_t e;
        e.name = name; e.reg_path = reg_path; e.res = res; e.flg = flg;
        sb.push_back(e);
    endtask

    // Bounded wait for the monitor to consume everything; returns at posedge+1.
    task automatic drain();
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.ALUControl = op;
        bus.a          = a;
        bus.b          = b;
    endtask

    task automatic run_vec(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic [3:0] flg);
        drive(op, a, b);
        push(name, 1'b0, res, flg);
        drain();
    endtask

    initial begin
        reset_n = 1'b0;
        bus.en  = 1'b1;
        drive(3'b000, 32'd2, 32'd3);
        @(posedge clk);
        @(posedge clk);
        #1;
        push("reset_hold", 1'b1, 32'd0, 4'b0000);
        drain();

        reset_n = 1'b1;
        bus.en  = 1'b0;

        run_vec("add_wrap",     3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        run_vec("add_ovf",      3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        run_vec("add_negneg",   3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111);
        run_vec("add_2_3",      3'b000, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000);
        run_vec("sub_eq",       3'b001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110);
        run_vec("sub_borrow",   3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000);
        run_vec("sub_ovf",      3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);
        run_vec("sub_3_7",      3'b001, 32'h0000_0003, 32'h0000_0007, 32'hFFFF_FFFC, 4'b1000);
        run_vec("and",          3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000);
        run_vec("orr",          3'b011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000);
        run_vec("eor",          3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'b1000);
        run_vec("bic",          3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100);
        run_vec("lsl_31",       3'b110, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b1000);
        run_vec("lsl_amt0",     3'b110, 32'h0000_000F, 32'h0000_0100, 32'h0000_000F, 4'b0000);
        run_vec("lsl_255",      3'b110, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_0000, 4'b0100);
        run_vec("lsr_32",       3'b111, 32'h8000_0000, 32'h0000_0020, 32'h0000_0000, 4'b0100);
        run_vec("lsr_4",        3'b111, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 4'b0000);
        run_vec("lsr_31",       3'b111, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000);

        // en was low throughout the combinational vectors: registers still hold reset value.
        push("hold_no_en", 1'b1, 32'd0, 4'b0000);
        drain();

        bus.en = 1'b1;
        drive(3'b000, 32'd2, 32'd3);
        @(posedge clk);
        #1;
        push("capture_2_3", 1'b1, 32'h0000_0005, 4'b0000);
        drain();

        bus.en = 1'b0;
        drive(3'b001, 32'h0000_0000, 32'h0000_0001);
        @(posedge clk);
        #1;
        push("hold_en0", 1'b1, 32'h0000_0005, 4'b0000);
        drain();

        // Pulse reset between edges with en low: only an asynchronous clear shows up.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        push("async_clear", 1'b1, 32'd0, 4'b0000);
        drain();

        bus.en = 1'b1;
        drive(3'b001, 32'h0000_0000, 32'h0000_0001);
        @(posedge clk);
        #1;
        push("capture_flags", 1'b1, 32'hFFFF_FFFF, 4'b1000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
